fir_sequencer: RTL and testbench
================================

// Module: fir_sequencer
// PURPOSE
// Control FSM for the FIR filter accelerator datapath. Per input sample it issues
// register-file/ALU micro-ops: shift the delay line, load the sample, clear the
// accumulator, then multiply-accumulate over NUM_TAPS taps.
// It also sequences coefficient loading and drives the sample counter (cnt_up/clear).
// It consumes one_k_samples from the sample counter.
// PARAMETERS
// NUM_TAPS  4  filter taps, legal 1..7; R0=acc, R1..R(N)=samples (R1 newest), R(8+i)=coef i, R15=temp
// PORTS
// clk                  in   1  system clock, rising edge
// rst                  in   1  asynchronous reset, active-high
// data_ready           in   1  1-cycle pulse: new sample on datapath sample bus
// new_coefficient_set  in   1  level: host requests coefficient reload
// coefficient_ready    in   1  1-cycle pulse: next coefficient on datapath coef bus
// overflow             in   1  datapath ALU overflow for op issued this cycle
// one_k_samples        in   1  sample-counter rollover flag
// cnt_up               out  1  increment sample counter
// clear                out  1  clear sample counter
// modwait              out  1  busy; high in every state except IDLE and ERR
// op                   out  3  0 NOP,1 COPY,2 LOAD_SAMPLE,3 LOAD_COEF,4 ADD,5 SUB,6 MUL
// src1/src2/dest       out  4  register-file indices for op
// err                  out  1  error indication
// coeff_done           out  1  1-cycle pulse: all coefficients loaded
// batch_done           out  1  1-cycle pulse: sample batch complete, counter cleared
// BEHAVIOUR
// - Outputs are Moore-decoded from registered state plus the tap index k.
// - Reset (async, any time, mid-op included): state=IDLE, k=0, pending=0.
//   All outputs 0: op=NOP, src/dest=0, modwait=0, err=0.
// - States: IDLE, CLR, COEF_WAIT, COEF_LD, SHIFT, STORE, ZERO, MUL, ACC, DONE, ERR.
// - Dispatch from IDLE/ERR, fixed priority:
//   one_k_samples -> CLR; new_coefficient_set -> COEF_WAIT; (data_ready|pending) -> SHIFT.
//   SHIFT is skipped and STORE entered directly when NUM_TAPS=1.
// - CLR: clear=1, batch_done=1 for exactly 1 cycle, then IDLE.
// - COEF_WAIT(k): wait for coefficient_ready, then COEF_LD.
//   COEF_LD: op=LOAD_COEF, dest=8+k, 1 cycle; k++. At k=NUM_TAPS: coeff_done=1, k=0, -> IDLE.
// - SHIFT(k=NUM_TAPS..2): op=COPY, src1=k-1, dest=k; one cycle each; then STORE.
// - STORE: op=LOAD_SAMPLE, dest=1. ZERO: op=SUB, src1=0, src2=0, dest=0.
// - MUL(i): op=MUL, src1=1+i, src2=8+i, dest=15.
//   ACC(i): op=ADD, src1=0, src2=15, dest=0. Run i=0..NUM_TAPS-1, then DONE.
// - DONE: cnt_up=1 for 1 cycle, then IDLE. Result is valid in R0 when modwait falls.
// - Latency: data_ready accept to modwait fall = (NUM_TAPS-1)+1+1+2*NUM_TAPS+1 cycles.
//   This is 14 cycles for NUM_TAPS=4.
// - Overflow: sampled only in MUL/ACC cycles.
//   If 1, next state=ERR; remaining ops and cnt_up are skipped.
// - Pending buffer, 1 deep:
//   - data_ready while modwait=1 sets pending; pending clears when the sample is dispatched.
//   - data_ready while pending=1 is overrun: the sequence completes normally.
//     The next state is then ERR instead of IDLE, and pending is discarded.
//   - data_ready during COEF_* also sets pending; coefficient loading is never interrupted.
// - ERR: err=1, modwait=0, op=NOP. Leave ERR via the normal dispatch rules; err=0 once dispatched.
// - Coefficient and sample bus contents are the host's responsibility; the sequencer only times the loads.
// TESTING
// - rst mid-MUL -> same cycle: op=0, modwait=0, err=0; next data_ready restarts at SHIFT.
// - NUM_TAPS=4, data_ready pulse in IDLE -> op sequence 1,1,1,2,5,(6,4)x4, then NOP.
//   modwait high 14 cycles; cnt_up high exactly on cycle 14.
// - new_coefficient_set=1, 4 coefficient_ready pulses 3 cycles apart -> LOAD_COEF dest 8,9,10,11.
//   coeff_done pulses once, after the 4th load.
// - overflow=1 during the 2nd ACC -> next cycle err=1, modwait=0, cnt_up never asserted.
//   The next data_ready clears err and runs the full 14 cycles.
// - 2nd data_ready at cycle 5 of a sample -> second sample starts the cycle after DONE, no IDLE gap.
//   A 3rd pulse while pending=1 -> ERR after the current DONE.
// - one_k_samples=1 with data_ready in IDLE -> CLR first (clear=1, batch_done=1); sample runs next.

Source files
------------

// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - micro-op sequencer for the FIR filter accelerator datapath
module fir_sequencer #(
    parameter int NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ready,
    input  logic       new_coefficient_set,
    input  logic       coefficient_ready,
    input  logic       overflow,
    input  logic       one_k_samples,
    output logic       cnt_up,
    output logic       clear,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       err,
    output logic       coeff_done,
    output logic       batch_done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_COEF_WAIT,
        S_COEF_LD,
        S_SHIFT,
        S_STORE,
        S_ZERO,
        S_MUL,
        S_ACC,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_COPY      = 3'd1;
    localparam logic [2:0] OP_LOAD_SMP  = 3'd2;
    localparam logic [2:0] OP_LOAD_COEF = 3'd3;
    localparam logic [2:0] OP_ADD       = 3'd4;
    localparam logic [2:0] OP_SUB       = 3'd5;
    localparam logic [2:0] OP_MUL       = 3'd6;

    localparam logic [2:0] TAPS     = 3'(NUM_TAPS);
    localparam logic [2:0] LAST_TAP = 3'(NUM_TAPS - 1);
    localparam logic [3:0] R_TEMP   = 4'd15;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic       pending_q, pending_d;
    logic       overrun_q, overrun_d;

    logic       can_dispatch;
    logic       seq_end;
    logic       take_sample;

    // Next-state, tap index and one-deep sample buffer bookkeeping
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        can_dispatch = 1'b0;
        seq_end      = 1'b0;
        take_sample  = 1'b0;

        case (state_q)
            S_IDLE, S_ERR: can_dispatch = 1'b1;
            S_CLR:         seq_end = 1'b1;
            S_COEF_WAIT: begin
                if (k_q == TAPS) begin
                    seq_end = 1'b1;
                    k_d     = 3'd0;
                end else if (coefficient_ready) begin
                    state_d = S_COEF_LD;
                end
            end
            S_COEF_LD: begin
                k_d     = k_q + 3'd1;
                state_d = S_COEF_WAIT;
            end
            S_SHIFT: begin
                if (k_q == 3'd2) begin
                    state_d = S_STORE;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            S_STORE: state_d = S_ZERO;
            S_ZERO: begin
                state_d = S_MUL;
                k_d     = 3'd0;
            end
            S_MUL: begin
                if (overflow) begin
                    state_d = S_ERR;
                    k_d     = 3'd0;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (overflow) begin
                    state_d = S_ERR;
                    k_d     = 3'd0;
                end else if (k_q == LAST_TAP) begin
                    state_d = S_DONE;
                    k_d     = 3'd0;
                end else begin
                    state_d = S_MUL;
                    k_d     = k_q + 3'd1;
                end
            end
            S_DONE: begin
                // An overrun during this sample turns the end of the sequence into ERR
                if (overrun_q) begin
                    seq_end = 1'b1;
                end else begin
                    state_d      = S_IDLE;
                    can_dispatch = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (seq_end) begin
            state_d = overrun_q ? S_ERR : S_IDLE;
        end

        // Fixed dispatch priority: counter clear, coefficient reload, then samples
        if (can_dispatch) begin
            if (one_k_samples) begin
                state_d = S_CLR;
            end else if (new_coefficient_set) begin
                state_d = S_COEF_WAIT;
                k_d     = 3'd0;
            end else if (data_ready || pending_q) begin
                take_sample = 1'b1;
                if (NUM_TAPS > 1) begin
                    state_d = S_SHIFT;
                    k_d     = TAPS;
                end else begin
                    state_d = S_STORE;
                    k_d     = 3'd0;
                end
            end
        end

        // A buffered sample is consumed first; a same-cycle pulse then refills the buffer
        if (take_sample) begin
            pending_d = pending_q & data_ready;
        end else if (data_ready) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (seq_end && overrun_q) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State, tap index and sample buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 3'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Moore output decode from the registered state and tap index
    always_comb begin
        op         = OP_NOP;
        src1       = 4'd0;
        src2       = 4'd0;
        dest       = 4'd0;
        modwait    = 1'b1;
        cnt_up     = 1'b0;
        clear      = 1'b0;
        err        = 1'b0;
        coeff_done = 1'b0;
        batch_done = 1'b0;

        case (state_q)
            S_IDLE: modwait = 1'b0;
            S_ERR: begin
                modwait = 1'b0;
                err     = 1'b1;
            end
            S_CLR: begin
                clear      = 1'b1;
                batch_done = 1'b1;
            end
            S_COEF_WAIT: coeff_done = (k_q == TAPS);
            S_COEF_LD: begin
                op   = OP_LOAD_COEF;
                dest = {1'b1, k_q};
            end
            S_SHIFT: begin
                op   = OP_COPY;
                src1 = {1'b0, k_q} - 4'd1;
                dest = {1'b0, k_q};
            end
            S_STORE: begin
                op   = OP_LOAD_SMP;
                dest = 4'd1;
            end
            S_ZERO: op = OP_SUB;
            S_MUL: begin
                op   = OP_MUL;
                src1 = {1'b0, k_q} + 4'd1;
                src2 = {1'b1, k_q};
                dest = R_TEMP;
            end
            S_ACC: begin
                op   = OP_ADD;
                src2 = R_TEMP;
            end
            S_DONE: cnt_up = 1'b1;
            default: modwait = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb/tb_fir_sequencer.sv - self-checking bench for fir_sequencer
module tb_fir_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data_ready = 1'b0;
    logic       new_coefficient_set = 1'b0;
    logic       coefficient_ready = 1'b0;
    logic       overflow = 1'b0;
    logic       one_k_samples = 1'b0;
    logic       cnt_up, clear, modwait, err, coeff_done, batch_done;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    int n_chk = 0;
    int n_pass = 0;

    fir_sequencer #(.NUM_TAPS(N)) dut (
        .clk(clk), .rst(rst), .data_ready(data_ready),
        .new_coefficient_set(new_coefficient_set),
        .coefficient_ready(coefficient_ready), .overflow(overflow),
        .one_k_samples(one_k_samples), .cnt_up(cnt_up), .clear(clear),
        .modwait(modwait), .op(op), .src1(src1), .src2(src2), .dest(dest),
        .err(err), .coeff_done(coeff_done), .batch_done(batch_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] d;
        logic       mw;
        logic       cu;
        logic       clr;
        logic       bd;
        logic       cd;
        logic       er;
    } ov_t;

    function automatic ov_t mk(input int o, input int a, input int b, input int d,
                               input int mw, input int cu, input int cl,
                               input int cd, input int er);
        ov_t v;
        v.op  = 3'(o);
        v.s1  = 4'(a);
        v.s2  = 4'(b);
        v.d   = 4'(d);
        v.mw  = 1'(mw);
        v.cu  = 1'(cu);
        v.clr = 1'(cl);
        v.bd  = 1'(cl);
        v.cd  = 1'(cd);
        v.er  = 1'(er);
        return v;
    endfunction

    // Behavioural model: a queue of the outputs each job will show, cycle by cycle
    ov_t q[$];
    bit  m_err, m_pend, m_ovr, m_coef;
    int  m_ck;

    function automatic ov_t m_exp();
        if (q.size() > 0) return q[0];
        if (m_coef) return mk(0, 0, 0, 0, 1, 0, 0, (m_ck == N) ? 1 : 0, 0);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, m_err ? 1 : 0);
    endfunction

    task automatic push_sample();
        for (int k = N; k >= 2; k--) q.push_back(mk(1, k - 1, 0, k, 1, 0, 0, 0, 0));
        q.push_back(mk(2, 0, 0, 1, 1, 0, 0, 0, 0));
        q.push_back(mk(5, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < N; i++) begin
            q.push_back(mk(6, 1 + i, 8 + i, 15, 1, 0, 0, 0, 0));
            q.push_back(mk(4, 0, 15, 0, 1, 0, 0, 0, 0));
        end
        q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_err = 0; m_pend = 0; m_ovr = 0; m_coef = 0; m_ck = 0;
        end else begin
            ov_t cur;
            bit  disp, resolve, took;
            cur = m_exp(); disp = 0; resolve = 0; took = 0;
            if (q.size() > 0) begin
                if (overflow && (cur.op == 3'd6 || cur.op == 3'd4)) begin
                    q.delete();
                    m_err = 1;
                end else begin
                    void'(q.pop_front());
                    if (q.size() == 0 && !m_coef) begin
                        if (cur.cu) begin
                            if (m_ovr) resolve = 1; else disp = 1;
                        end else if (cur.clr && m_ovr) begin
                            resolve = 1;
                        end
                    end
                end
            end else if (m_coef) begin
                if (m_ck == N) begin
                    m_coef = 0;
                    if (m_ovr) resolve = 1;
                end else if (coefficient_ready) begin
                    q.push_back(mk(3, 0, 0, 8 + m_ck, 1, 0, 0, 0, 0));
                    m_ck++;
                end
            end else begin
                disp = 1;
            end
            if (disp) begin
                if (one_k_samples) begin
                    q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0));
                    m_err = 0;
                end else if (new_coefficient_set) begin
                    m_coef = 1; m_ck = 0; m_err = 0;
                end else if (data_ready || m_pend) begin
                    push_sample();
                    m_err = 0; took = 1;
                end
            end
            if (took) m_pend = m_pend && data_ready;
            else if (data_ready) begin
                if (m_pend) m_ovr = 1; else m_pend = 1;
            end
            if (resolve) begin
                m_err = 1; m_pend = 0; m_ovr = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        ov_t a, e;
        a = {op, src1, src2, dest, modwait, cnt_up, clear, batch_done, coeff_done, err};
        e = m_exp();
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL model_cmp t=%0t dut=%h model=%h", $time, a, e);
    end

    task automatic chk(input string name, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, act, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int rec_op[64], rec_mw[64], rec_cu[64], rec_er[64], rec_d[64];

    // Record outputs of cycles 0..n-1, pulsing data_ready in the listed cycles
    task automatic run_job(input int n, input int d1, input int d2, input int d3);
        for (int c = 0; c < n; c++) begin
            data_ready = (c == d1 || c == d2 || c == d3);
            rec_op[c] = int'(op); rec_mw[c] = int'(modwait); rec_cu[c] = int'(cnt_up);
            rec_er[c] = int'(err); rec_d[c] = int'(dest);
            cyc();
        end
        data_ready = 1'b0;
    endtask

    int exp_ops[16];
    int cnt, cnt2, at;
    int dests[$];

    initial begin
        exp_ops = '{0, 1, 1, 1, 2, 5, 6, 4, 6, 4, 6, 4, 6, 4, 0, 0};

        // Reset: every output low
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({op, src1, src2, dest, modwait, cnt_up, clear, err, coeff_done, batch_done}), 0);
        rst = 1'b0;
        cyc();

        // Single sample: op stream, 14 busy cycles, cnt_up on cycle 14
        run_job(17, 0, -1, -1);
        cnt = 0; cnt2 = 0; at = -1;
        for (int c = 1; c < 16; c++) begin
            chk($sformatf("sample_op_c%0d", c), rec_op[c], exp_ops[c]);
            cnt += rec_mw[c];
            cnt2 += rec_cu[c];
            if (rec_cu[c] == 1) at = c;
        end
        chk("modwait_cycles", cnt, 14);
        chk("cnt_up_count", cnt2, 1);
        chk("cnt_up_cycle", at, 14);
        chk("shift_first_dest", rec_d[1], 4);

        // Coefficient load: four pulses three cycles apart
        new_coefficient_set = 1'b1;
        cyc();
        new_coefficient_set = 1'b0;
        cnt = 0; at = -1;
        for (int c = 1; c < 17; c++) begin
            coefficient_ready = (c == 2 || c == 5 || c == 8 || c == 11);
            if (op == 3'd3) dests.push_back(int'(dest));
            if (coeff_done) begin cnt++; at = c; end
            cyc();
        end
        coefficient_ready = 1'b0;
        chk("coef_loads", dests.size(), 4);
        for (int i = 0; i < 4 && i < dests.size(); i++) chk($sformatf("coef_dest%0d", i), dests[i], 8 + i);
        chk("coeff_done_count", cnt, 1);
        chk("coeff_done_cycle", at, 13);

        // Overflow on the 2nd ACC: error, no cnt_up, then a clean restart
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        repeat (8) cyc();
        chk("acc2_op", int'(op), 4);
        overflow = 1'b1;
        cyc();
        overflow = 1'b0;
        chk("ovf_err", int'(err), 1);
        chk("ovf_modwait", int'(modwait), 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin cnt += int'(cnt_up); cyc(); end
        chk("ovf_no_cnt_up", cnt, 0);
        run_job(17, 0, -1, -1);
        chk("restart_err_clear", rec_er[1], 0);
        cnt = 0;
        for (int c = 1; c < 17; c++) cnt += rec_mw[c];
        chk("restart_modwait_cycles", cnt, 14);

        // Back-to-back: second pulse at cycle 5 starts right after DONE
        run_job(32, 0, 5, -1);
        cnt = 0;
        for (int c = 1; c < 29; c++) cnt += rec_mw[c];
        chk("b2b_busy_cycles", cnt, 28);
        chk("b2b_done1", rec_cu[14], 1);
        chk("b2b_second_op", rec_op[15], 1);
        chk("b2b_done2", rec_cu[28], 1);
        chk("b2b_idle_after", rec_mw[29], 0);

        // Overrun: third pulse while one is pending ends in ERR after DONE
        run_job(20, 0, 5, 8);
        chk("ovr_done", rec_cu[14], 1);
        chk("ovr_err", rec_er[15], 1);
        chk("ovr_modwait", rec_mw[15], 0);
        chk("ovr_discard", rec_mw[19], 0);

        // Counter rollover beats a simultaneous sample
        one_k_samples = 1'b1;
        data_ready = 1'b1;
        cyc();
        one_k_samples = 1'b0;
        data_ready = 1'b0;
        chk("clr_clear", int'(clear), 1);
        chk("clr_batch_done", int'(batch_done), 1);
        chk("clr_err", int'(err), 0);
        cyc();
        chk("clr_then_idle", int'(modwait), 0);
        cyc();
        chk("clr_then_sample", int'(op), 1);
        repeat (16) cyc();

        // Asynchronous reset mid-MUL, then restart
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        repeat (5) cyc();
        chk("pre_rst_mul", int'(op), 6);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_op", int'(op), 0);
        chk("rst_modwait", int'(modwait), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        cyc();
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
        chk("post_rst_op", int'(op), 1);
        chk("post_rst_dest", int'(dest), 4);
        repeat (16) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
